// File: rtl/uart_alu_interface_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_alu_interface_if
// Description : UART RX/TX handshake and ALU status bundle for the controller
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_alu_interface_if #(
    parameter int SIZEDATA = 8
);
    logic                i_rx_done;
    logic [SIZEDATA-1:0] i_rx_data;
    logic                i_tx_done;
    logic                o_tx_signal;
    logic [SIZEDATA-1:0] o_tx_result;
    logic                o_busy;
    logic                o_op_error;

    modport master (
        output i_rx_done, i_rx_data, i_tx_done,
        input  o_tx_signal, o_tx_result, o_busy, o_op_error
    );

    modport slave (
        input  i_rx_done, i_rx_data, i_tx_done,
        output o_tx_signal, o_tx_result, o_busy, o_op_error
    );
endinterface
`default_nettype wire

// File: rtl/uart_alu_interface.sv
`default_nettype none
// ============================================================================
// Module      : uart_alu_interface
// Description : Collects A, B, opcode bytes from UART RX, computes the ALU
//               result and hands it to the UART TX, waiting for completion.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_alu_interface #(
    parameter int SIZEDATA = 8,
    parameter int NB_OP    = 6
) (
    input  wire logic           i_clock,
    input  wire logic           i_reset,
    uart_alu_interface_if.slave bus
);
    localparam logic [2:0] c_GET_A   = 3'd0;
    localparam logic [2:0] c_GET_B   = 3'd1;
    localparam logic [2:0] c_GET_OP  = 3'd2;
    localparam logic [2:0] c_COMPUTE = 3'd3;
    localparam logic [2:0] c_SEND    = 3'd4;
    localparam logic [2:0] c_WAIT_TX = 3'd5;

    localparam logic [NB_OP-1:0] c_OP_SRL = NB_OP'(6'h02);
    localparam logic [NB_OP-1:0] c_OP_SRA = NB_OP'(6'h03);
    localparam logic [NB_OP-1:0] c_OP_ADD = NB_OP'(6'h20);
    localparam logic [NB_OP-1:0] c_OP_SUB = NB_OP'(6'h22);
    localparam logic [NB_OP-1:0] c_OP_AND = NB_OP'(6'h24);
    localparam logic [NB_OP-1:0] c_OP_OR  = NB_OP'(6'h25);
    localparam logic [NB_OP-1:0] c_OP_XOR = NB_OP'(6'h26);
    localparam logic [NB_OP-1:0] c_OP_NOR = NB_OP'(6'h27);

    logic [2:0]          r_state;
    logic [2:0]          w_state_next;
    logic [SIZEDATA-1:0] r_a;
    logic [SIZEDATA-1:0] r_b;
    logic [NB_OP-1:0]    r_op;
    logic [SIZEDATA-1:0] r_tx_result;
    logic                r_tx_signal;
    logic                r_busy;
    logic                r_op_error;
    logic [SIZEDATA-1:0] w_result;
    logic                w_unsupported;

    // Opcode occupies only the low NB_OP bits of the received byte.
    wire w_unused_rx_hi = ^bus.i_rx_data[SIZEDATA-1:NB_OP];

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_GET_A:   if (bus.i_rx_done) w_state_next = c_GET_B;
            c_GET_B:   if (bus.i_rx_done) w_state_next = c_GET_OP;
            c_GET_OP:  if (bus.i_rx_done) w_state_next = c_COMPUTE;
            c_COMPUTE: w_state_next = c_SEND;
            c_SEND:    w_state_next = c_WAIT_TX;
            c_WAIT_TX: if (bus.i_tx_done) w_state_next = c_GET_A;
            default:   w_state_next = c_GET_A;
        endcase
    end

    // Shift amount is the full B byte, so oversized shifts saturate naturally.
    always_comb begin
        w_result      = '0;
        w_unsupported = 1'b0;
        case (r_op)
            c_OP_ADD: w_result = r_a + r_b;
            c_OP_SUB: w_result = r_a - r_b;
            c_OP_AND: w_result = r_a & r_b;
            c_OP_OR:  w_result = r_a | r_b;
            c_OP_XOR: w_result = r_a ^ r_b;
            c_OP_NOR: w_result = ~(r_a | r_b);
            c_OP_SRA: w_result = $signed(r_a) >>> r_b;
            c_OP_SRL: w_result = r_a >> r_b;
            default:  w_unsupported = 1'b1;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state     <= c_GET_A;
            r_a         <= '0;
            r_b         <= '0;
            r_op        <= '0;
            r_tx_result <= '0;
            r_tx_signal <= 1'b0;
            r_busy      <= 1'b0;
            r_op_error  <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_tx_signal <= (w_state_next == c_SEND);
            r_busy      <= (w_state_next == c_COMPUTE) || (w_state_next == c_SEND) ||
                           (w_state_next == c_WAIT_TX);
            if (bus.i_rx_done && r_state == c_GET_A) begin
                r_a        <= bus.i_rx_data;
                r_op_error <= 1'b0;
            end
            if (bus.i_rx_done && r_state == c_GET_B)
                r_b <= bus.i_rx_data;
            if (bus.i_rx_done && r_state == c_GET_OP)
                r_op <= bus.i_rx_data[NB_OP-1:0];
            if (r_state == c_COMPUTE) begin
                r_tx_result <= w_result;
                r_op_error  <= w_unsupported;
            end
        end
    end

    assign bus.o_tx_signal = r_tx_signal;
    assign bus.o_tx_result = r_tx_result;
    assign bus.o_busy      = r_busy;
    assign bus.o_op_error  = r_op_error;
endmodule
`default_nettype wire

// File: tb/tb_uart_alu_interface.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_alu_interface
// Description : Directed-vector scoreboard bench for uart_alu_interface
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_alu_interface;
    typedef struct {
        logic [7:0] res;
        logic       err;
        int         cyc;
    } exp_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] op;
        logic [7:0] res;
        logic       err;
        int         junk;
        logic       chk_clear;
    } vec_t;

    logic clk;
    logic rst;
    int   cyc;
    int   checks;
    int   fails;
    exp_t sb_q[$];
    vec_t vecs[13];

    uart_alu_interface_if #(.SIZEDATA(8)) bus ();

    uart_alu_interface #(.SIZEDATA(8), .NB_OP(6)) dut (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every tx start pulse pops one expected frame.
    initial begin
        logic prev_tx;
        exp_t e;
        prev_tx = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.o_tx_signal === 1'b1) begin
                check("tx_pulse_width", {31'd0, prev_tx}, 32'd0);
                if (sb_q.size() == 0) begin
                    check("unexpected_tx", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("tx_result", {24'd0, bus.o_tx_result}, {24'd0, e.res});
                    check("op_error",  {31'd0, bus.o_op_error},  {31'd0, e.err});
                    check("tx_latency", cyc, e.cyc);
                end
            end
            prev_tx = bus.o_tx_signal;
        end
    end

    task automatic send_byte(input logic [7:0] d);
        bus.i_rx_done = 1'b1;
        bus.i_rx_data = d;
        @(posedge clk);
        #1;
        bus.i_rx_done = 1'b0;
        bus.i_rx_data = 8'h00;
    endtask

    task automatic run_frame(input vec_t v);
        bit got;
        exp_t e;
        send_byte(v.a);
        if (v.chk_clear) check("op_error_cleared", {31'd0, bus.o_op_error}, 32'd0);
        send_byte(v.b);
        send_byte(v.op);
        e.res = v.res;
        e.err = v.err;
        e.cyc = cyc + 1;
        sb_q.push_back(e);
        check("busy_compute", {31'd0, bus.o_busy}, 32'd1);
        got = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            if (bus.o_tx_signal === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) check("tx_timeout", 32'd1, 32'd0);
        // Bytes arriving while the transmitter is busy must be dropped.
        for (int k = 0; k < v.junk; k++) send_byte(8'hAA);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        check("busy_wait_tx", {31'd0, bus.o_busy}, 32'd1);
        bus.i_tx_done = 1'b1;
        @(posedge clk);
        #1;
        bus.i_tx_done = 1'b0;
        check("busy_after_tx_done", {31'd0, bus.o_busy}, 32'd0);
    endtask

    initial begin
        checks = 0;
        fails  = 0;
        vecs[0]  = '{8'h05, 8'h03, 8'h20, 8'h08, 1'b0, 0, 1'b0};
        vecs[1]  = '{8'h03, 8'h05, 8'h22, 8'hFE, 1'b0, 0, 1'b0};
        vecs[2]  = '{8'hF0, 8'h0F, 8'h27, 8'h00, 1'b0, 0, 1'b0};
        vecs[3]  = '{8'hFF, 8'h01, 8'h20, 8'h00, 1'b0, 0, 1'b0};
        vecs[4]  = '{8'h80, 8'h02, 8'h03, 8'hE0, 1'b0, 0, 1'b0};
        vecs[5]  = '{8'h80, 8'h02, 8'h02, 8'h20, 1'b0, 0, 1'b0};
        vecs[6]  = '{8'h80, 8'h09, 8'h03, 8'hFF, 1'b0, 0, 1'b0};
        vecs[7]  = '{8'h80, 8'h09, 8'h02, 8'h00, 1'b0, 0, 1'b0};
        vecs[8]  = '{8'h01, 8'h01, 8'h3F, 8'h00, 1'b1, 0, 1'b0};
        vecs[9]  = '{8'h0C, 8'h0A, 8'h24, 8'h08, 1'b0, 0, 1'b1};
        vecs[10] = '{8'h0C, 8'h0A, 8'h25, 8'h0E, 1'b0, 3, 1'b0};
        vecs[11] = '{8'h0C, 8'h0A, 8'h26, 8'h06, 1'b0, 0, 1'b0};
        vecs[12] = '{8'h07, 8'h01, 8'hE0, 8'h08, 1'b0, 0, 1'b0};

        bus.i_rx_done = 1'b0;
        bus.i_rx_data = 8'h00;
        bus.i_tx_done = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_tx_signal", {31'd0, bus.o_tx_signal}, 32'd0);
        check("reset_tx_result", {24'd0, bus.o_tx_result}, 32'd0);
        check("reset_busy",      {31'd0, bus.o_busy},      32'd0);
        check("reset_op_error",  {31'd0, bus.o_op_error},  32'd0);

        // A stray tx_done while idle must not disturb the collector.
        bus.i_tx_done = 1'b1;
        @(posedge clk);
        #1;
        bus.i_tx_done = 1'b0;

        foreach (vecs[i]) run_frame(vecs[i]);

        // Reset mid-frame after A and B: partial bytes discarded.
        send_byte(8'h11);
        send_byte(8'h22);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midreset_tx_result", {24'd0, bus.o_tx_result}, 32'd0);
        check("midreset_tx_signal", {31'd0, bus.o_tx_signal}, 32'd0);
        check("midreset_busy",      {31'd0, bus.o_busy},      32'd0);
        check("midreset_op_error",  {31'd0, bus.o_op_error},  32'd0);
        run_frame('{8'h02, 8'h02, 8'h24, 8'h02, 1'b0, 0, 1'b0});

        repeat (4) @(posedge clk);
        #1;
        check("scoreboard_empty", sb_q.size(), 32'd0);
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/uart_alu_interface.md
# uart_alu_interface

Byte-stream controller sitting between the UART receiver/transmitter pair and the ALU datapath. Collects three received bytes (operand A, operand B, opcode), computes the ALU result internally, then hands the result byte to the UART transmitter and waits for its completion before accepting the next frame. Consumes the RX `done`/`data` outputs of the UART block and drives its TX `signal`/`result` inputs.

## Interface
- `SIZEDATA`, 8: width of operands, result and UART data bytes (≥ 6).
- `NB_OP`, 6: opcode field width; opcode is `i_rx_data[NB_OP-1:0]`, upper bits ignored.

- `i_clock`  in  1  system clock; all logic on rising edge.
- `i_reset`  in  1  reset; synchronous, active-high.
- `i_rx_done`  in  1  one-cycle pulse: `i_rx_data` holds a new byte.
- `i_rx_data`  in  SIZEDATA  received byte, valid only when `i_rx_done`=1.
- `i_tx_done`  in  1  one-cycle pulse from transmitter: stop bit sent.
- `o_tx_signal`  out  1  one-cycle start pulse to transmitter.
- `o_tx_result`  out  SIZEDATA  byte to transmit; registered, stable from `o_tx_signal` until next frame's result.
- `o_busy`  out  1  high in COMPUTE, SEND, WAIT_TX.
- `o_op_error`  out  1  high when last computed opcode was unsupported; cleared when the next operand A is captured.

## Operation
- States: GET_A → GET_B → GET_OP → COMPUTE → SEND → WAIT_TX → GET_A.
- GET_A: on `i_rx_done`, register A, clear `o_op_error`, go GET_B. GET_B: on `i_rx_done`, register B, go GET_OP. GET_OP: on `i_rx_done`, register opcode, go COMPUTE.
- COMPUTE (1 cycle): register result into `o_tx_result`, set `o_op_error` if opcode unsupported; go SEND.
- SEND (1 cycle): `o_tx_signal`=1; go WAIT_TX.
- WAIT_TX: stay until `i_tx_done`=1, then go GET_A.
- Opcodes (NB_OP bits): ADD 0x20 A+B; SUB 0x22 A−B; AND 0x24; OR 0x25; XOR 0x26; NOR 0x27 ~(A|B); SRA 0x03 A>>>B; SRL 0x02 A>>B.
- Arithmetic: ADD/SUB wrap modulo 2^SIZEDATA, no carry/overflow output. Shifts use full B as amount; B ≥ SIZEDATA gives SRL=0, SRA=all bits equal to A[MSB].
- Unsupported opcode: result 0, `o_op_error`=1, result still transmitted.
- `i_rx_done` in COMPUTE, SEND, WAIT_TX: byte dropped, no state effect. `i_tx_done` outside WAIT_TX: ignored.
- Reset: state GET_A; A, B, opcode, `o_tx_result` = 0; `o_tx_signal`=0, `o_busy`=0, `o_op_error`=0. Reset mid-frame discards partial bytes; reset during WAIT_TX abandons the wait (transmitter is reset by the same signal).

## Timing
- `i_rx_done` for opcode sampled at edge N → COMPUTE during cycle N+1 → `o_tx_result` valid and `o_tx_signal`=1 during cycle N+2 → WAIT_TX from N+3.
- `i_tx_done` sampled at edge M in WAIT_TX → GET_A from M+1; an `i_rx_done` at M+1 is captured as A (zero dead cycles).
- Back-to-back `i_rx_done` on consecutive cycles each captured (A, B, opcode in 3 cycles).
- `o_busy` registered with state: high exactly in cycles N+1 through M inclusive.
- `o_tx_signal` never high for more than one cycle per frame; exactly one per completed frame.

## Test plan
- A=0x05, B=0x03, op=0x20 → one `o_tx_signal` pulse, `o_tx_result`=0x08 two cycles after opcode byte, `o_op_error`=0.
- A=0x03, B=0x05, op=0x22 → 0xFE; A=0xF0, B=0x0F, op=0x27 → 0x00; A=0xFF, B=0x01, op=0x20 → 0x00 (wrap).
- A=0x80, B=0x02, op=0x03 → 0xE0; op=0x02 → 0x20; A=0x80, B=0x09, op=0x03 → 0xFF, op=0x02 → 0x00.
- A=0x01, B=0x01, op=0x3F → result 0x00, `o_op_error`=1; next frame's A byte clears it.
- Extra `i_rx_done` bytes during WAIT_TX → ignored; after `i_tx_done`, next three bytes form a fresh frame with correct result.
- `i_reset` asserted after A and B captured → all outputs 0, state GET_A; following frame 0x02,0x02,0x24 → 0x02.
